// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: field widths, the ALU op
// encodings produced by the main control unit, and the packed bundle of
// single-bit control lines that travels from ID into EX.
package id_ex_stage_pkg;

    // Default field widths of the MIPS datapath.
    localparam int DATA_SZ     = 32;
    localparam int REG_ADDR_SZ = 5;
    localparam int ALU_OP_SZ   = 3;
    localparam int FUNCT_SZ    = 6;
    localparam int SHAMT_SZ    = 5;

    // Main-control ALU op codes; ALU_OP_RTYPE defers to the funct field.
    typedef enum logic [ALU_OP_SZ-1:0] {
        ALU_OP_ADD   = 3'b000,
        ALU_OP_SUB   = 3'b001,
        ALU_OP_RTYPE = 3'b010,
        ALU_OP_AND   = 3'b011,
        ALU_OP_OR    = 3'b100,
        ALU_OP_XOR   = 3'b101,
        ALU_OP_SLT   = 3'b110,
        ALU_OP_LUI   = 3'b111
    } alu_op_e;

    // Single-bit main-control lines carried through the stage as one unit.
    typedef struct packed {
        logic reg_dst;
        logic jal_sel;
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic bds_sel;
        logic mem_to_reg;
    } ctrl_t;

    // Control value of a bubble: nothing is read, written or committed.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : id_ex_stage_pkg

// File: rtl/load_use_detector.sv
// Load-use hazard detector. Flags when the instruction in ID needs a register
// that the load currently in EX has not yet fetched from memory. Purely
// combinational; the stall is suppressed while the stage is frozen by the
// debug unit or while a flush already turns the ID instruction into a bubble.
module load_use_detector
    import id_ex_stage_pkg::*;
#(
    parameter int REG_ADDR_SZ = id_ex_stage_pkg::REG_ADDR_SZ
) (
    input  logic                   valid_e,
    input  logic                   mem_read_e,
    input  logic [REG_ADDR_SZ-1:0] rt_e,
    input  logic [REG_ADDR_SZ-1:0] rs_d,
    input  logic [REG_ADDR_SZ-1:0] rt_d,
    input  logic                   uses_rt_d,
    input  logic                   enable,
    input  logic                   flush,
    output logic                   stall
);

    logic load_in_ex;
    logic rs_dep;
    logic rt_dep;
    logic hazard;

    // A load targeting $0 produces nothing anyone can depend on.
    assign load_in_ex = valid_e & mem_read_e & (rt_e != '0);
    assign rs_dep     = (rt_e == rs_d);
    assign rt_dep     = uses_rt_d & (rt_e == rt_d);
    assign hazard     = load_in_ex & (rs_dep | rt_dep);

    // Freeze and flush both outrank the hazard, so neither may hold upstream.
    assign stall      = hazard & enable & ~flush;

endmodule : load_use_detector

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the MIPS pipeline. Captures the decoded control
// lines and operands from ID each cycle, inserts a bubble on a flush or a
// load-use hazard, and freezes completely while the debug unit holds
// i_enable low.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_SZ     = id_ex_stage_pkg::DATA_SZ,
    parameter int REG_ADDR_SZ = id_ex_stage_pkg::REG_ADDR_SZ,
    parameter int ALU_OP_SZ   = id_ex_stage_pkg::ALU_OP_SZ,
    parameter int FUNCT_SZ    = id_ex_stage_pkg::FUNCT_SZ
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_enable,
    input  logic                   i_flush,

    // Main-control lines from ID
    input  logic [ALU_OP_SZ-1:0]   i_alu_op_D,
    input  logic                   i_reg_dst_D,
    input  logic                   i_jal_sel_D,
    input  logic                   i_alu_src_D,
    input  logic                   i_mem_read_D,
    input  logic                   i_mem_write_D,
    input  logic                   i_reg_write_D,
    input  logic                   i_bds_sel_D,
    input  logic                   i_mem_to_reg_D,
    input  logic                   i_uses_rt_D,

    // Operands and instruction fields from ID
    input  logic [DATA_SZ-1:0]     i_rs_data_D,
    input  logic [DATA_SZ-1:0]     i_rt_data_D,
    input  logic [DATA_SZ-1:0]     i_imm_ext_D,
    input  logic [DATA_SZ-1:0]     i_pc8_D,
    input  logic [REG_ADDR_SZ-1:0] i_rs_D,
    input  logic [REG_ADDR_SZ-1:0] i_rt_D,
    input  logic [REG_ADDR_SZ-1:0] i_rd_D,
    input  logic [SHAMT_SZ-1:0]    i_shamt_D,
    input  logic [FUNCT_SZ-1:0]    i_funct_D,

    // Registered control lines for EX
    output logic [ALU_OP_SZ-1:0]   o_alu_op_E,
    output logic                   o_reg_dst_E,
    output logic                   o_jal_sel_E,
    output logic                   o_alu_src_E,
    output logic                   o_mem_read_E,
    output logic                   o_mem_write_E,
    output logic                   o_reg_write_E,
    output logic                   o_bds_sel_E,
    output logic                   o_mem_to_reg_E,

    // Registered operands and fields for EX
    output logic [DATA_SZ-1:0]     o_rs_data_E,
    output logic [DATA_SZ-1:0]     o_rt_data_E,
    output logic [DATA_SZ-1:0]     o_imm_ext_E,
    output logic [DATA_SZ-1:0]     o_pc8_E,
    output logic [REG_ADDR_SZ-1:0] o_rs_E,
    output logic [REG_ADDR_SZ-1:0] o_rt_E,
    output logic [REG_ADDR_SZ-1:0] o_rd_E,
    output logic [SHAMT_SZ-1:0]    o_shamt_E,
    output logic [FUNCT_SZ-1:0]    o_funct_E,

    output logic                   o_valid_E,
    output logic                   o_stall_D
);

    ctrl_t                  ctrl_d;
    ctrl_t                  ctrl_q;
    logic [ALU_OP_SZ-1:0]   alu_op_q;
    logic                   valid_q;

    logic [DATA_SZ-1:0]     rs_data_q;
    logic [DATA_SZ-1:0]     rt_data_q;
    logic [DATA_SZ-1:0]     imm_ext_q;
    logic [DATA_SZ-1:0]     pc8_q;
    logic [REG_ADDR_SZ-1:0] rs_q;
    logic [REG_ADDR_SZ-1:0] rt_q;
    logic [REG_ADDR_SZ-1:0] rd_q;
    logic [SHAMT_SZ-1:0]    shamt_q;
    logic [FUNCT_SZ-1:0]    funct_q;

    logic                   stall;
    logic                   bubble;

    assign ctrl_d = '{
        reg_dst:    i_reg_dst_D,
        jal_sel:    i_jal_sel_D,
        alu_src:    i_alu_src_D,
        mem_read:   i_mem_read_D,
        mem_write:  i_mem_write_D,
        reg_write:  i_reg_write_D,
        bds_sel:    i_bds_sel_D,
        mem_to_reg: i_mem_to_reg_D
    };

    load_use_detector #(
        .REG_ADDR_SZ (REG_ADDR_SZ)
    ) u_load_use_detector (
        .valid_e    (valid_q),
        .mem_read_e (ctrl_q.mem_read),
        .rt_e       (rt_q),
        .rs_d       (i_rs_D),
        .rt_d       (i_rt_D),
        .uses_rt_d  (i_uses_rt_D),
        .enable     (i_enable),
        .flush      (i_flush),
        .stall      (stall)
    );

    // The detector already masks the stall during a flush, so the two
    // bubble sources can simply be OR-ed.
    assign bubble = i_flush | stall;

    // Control path: hold when frozen, kill on flush or hazard, else capture.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (!i_reset_n) begin
            alu_op_q <= '0;
            ctrl_q   <= CTRL_BUBBLE;
            valid_q  <= 1'b0;
        end else if (i_enable) begin
            if (bubble) begin
                alu_op_q <= '0;
                ctrl_q   <= CTRL_BUBBLE;
                valid_q  <= 1'b0;
            end else begin
                alu_op_q <= i_alu_op_D;
                ctrl_q   <= ctrl_d;
                valid_q  <= 1'b1;
            end
        end
    end

    // Data path: captures on every enabled edge, bubbles included, so the
    // contents stay deterministic even when nothing downstream reads them.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_ext_q <= '0;
            pc8_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            funct_q   <= '0;
        end else if (i_enable) begin
            rs_data_q <= i_rs_data_D;
            rt_data_q <= i_rt_data_D;
            imm_ext_q <= i_imm_ext_D;
            pc8_q     <= i_pc8_D;
            rs_q      <= i_rs_D;
            rt_q      <= i_rt_D;
            rd_q      <= i_rd_D;
            shamt_q   <= i_shamt_D;
            funct_q   <= i_funct_D;
        end
    end

    assign o_alu_op_E     = alu_op_q;
    assign o_reg_dst_E    = ctrl_q.reg_dst;
    assign o_jal_sel_E    = ctrl_q.jal_sel;
    assign o_alu_src_E    = ctrl_q.alu_src;
    assign o_mem_read_E   = ctrl_q.mem_read;
    assign o_mem_write_E  = ctrl_q.mem_write;
    assign o_reg_write_E  = ctrl_q.reg_write;
    assign o_bds_sel_E    = ctrl_q.bds_sel;
    assign o_mem_to_reg_E = ctrl_q.mem_to_reg;

    assign o_rs_data_E    = rs_data_q;
    assign o_rt_data_E    = rt_data_q;
    assign o_imm_ext_E    = imm_ext_q;
    assign o_pc8_E        = pc8_q;
    assign o_rs_E         = rs_q;
    assign o_rt_E         = rt_q;
    assign o_rd_E         = rd_q;
    assign o_shamt_E      = shamt_q;
    assign o_funct_E      = funct_q;

    assign o_valid_E      = valid_q;
    assign o_stall_D      = stall;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a table of instruction vectors with
// expected stall and expected next-state kind (capture / bubble / hold),
// compared through a scoreboard queue, plus hand-written reset sequences.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    // Every D/E field of the stage in one packed record.
    typedef struct packed {
        logic [2:0]  alu_op;
        logic        reg_dst;
        logic        jal_sel;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        bds_sel;
        logic        mem_to_reg;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [31:0] pc8;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
    } stage_t;

    typedef enum logic [1:0] {K_CAP, K_BUB, K_HOLD} kind_e;

    typedef struct {
        stage_t d;
        logic   uses_rt;
        logic   enable;
        logic   flush;
        logic   exp_stall;
        kind_e  kind;
    } vec_t;

    typedef struct {
        stage_t e;
        logic   valid;
    } exp_t;

    localparam int NVEC = 28;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   enable;
    logic   flush;
    logic   uses_rt;
    stage_t d;
    stage_t e_act;

    logic [2:0]  e_alu_op;
    logic        e_reg_dst, e_jal_sel, e_alu_src, e_mem_read;
    logic        e_mem_write, e_reg_write, e_bds_sel, e_mem_to_reg;
    logic [31:0] e_rs_data, e_rt_data, e_imm_ext, e_pc8;
    logic [4:0]  e_rs, e_rt, e_rd, e_shamt;
    logic [5:0]  e_funct;
    logic        valid_e;
    logic        stall;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t model;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_enable       (enable),
        .i_flush        (flush),
        .i_alu_op_D     (d.alu_op),
        .i_reg_dst_D    (d.reg_dst),
        .i_jal_sel_D    (d.jal_sel),
        .i_alu_src_D    (d.alu_src),
        .i_mem_read_D   (d.mem_read),
        .i_mem_write_D  (d.mem_write),
        .i_reg_write_D  (d.reg_write),
        .i_bds_sel_D    (d.bds_sel),
        .i_mem_to_reg_D (d.mem_to_reg),
        .i_uses_rt_D    (uses_rt),
        .i_rs_data_D    (d.rs_data),
        .i_rt_data_D    (d.rt_data),
        .i_imm_ext_D    (d.imm_ext),
        .i_pc8_D        (d.pc8),
        .i_rs_D         (d.rs),
        .i_rt_D         (d.rt),
        .i_rd_D         (d.rd),
        .i_shamt_D      (d.shamt),
        .i_funct_D      (d.funct),
        .o_alu_op_E     (e_alu_op),
        .o_reg_dst_E    (e_reg_dst),
        .o_jal_sel_E    (e_jal_sel),
        .o_alu_src_E    (e_alu_src),
        .o_mem_read_E   (e_mem_read),
        .o_mem_write_E  (e_mem_write),
        .o_reg_write_E  (e_reg_write),
        .o_bds_sel_E    (e_bds_sel),
        .o_mem_to_reg_E (e_mem_to_reg),
        .o_rs_data_E    (e_rs_data),
        .o_rt_data_E    (e_rt_data),
        .o_imm_ext_E    (e_imm_ext),
        .o_pc8_E        (e_pc8),
        .o_rs_E         (e_rs),
        .o_rt_E         (e_rt),
        .o_rd_E         (e_rd),
        .o_shamt_E      (e_shamt),
        .o_funct_E      (e_funct),
        .o_valid_E      (valid_e),
        .o_stall_D      (stall)
    );

    assign e_act = {e_alu_op, e_reg_dst, e_jal_sel, e_alu_src, e_mem_read,
                    e_mem_write, e_reg_write, e_bds_sel, e_mem_to_reg,
                    e_rs_data, e_rt_data, e_imm_ext, e_pc8,
                    e_rs, e_rt, e_rd, e_shamt, e_funct};

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_stage(input string name, input stage_t act, input stage_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction builders: control lines as the main control unit decodes them.
    function automatic stage_t mk_addu(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd);
        stage_t s;
        s           = '0;
        s.alu_op    = ALU_OP_RTYPE;
        s.reg_dst   = 1'b1;
        s.reg_write = 1'b1;
        s.rs        = rs;
        s.rt        = rt;
        s.rd        = rd;
        s.shamt     = rd;
        s.funct     = 6'h21;
        s.rs_data   = 32'h1000_0000 | {27'd0, rs};
        s.rt_data   = 32'h2000_0000 | {27'd0, rt};
        s.imm_ext   = {16'h0, rd, 5'h0, 6'h21};
        s.pc8       = 32'h0040_0100 | {27'd0, rd};
        return s;
    endfunction

    function automatic stage_t mk_lw(input logic [4:0] rs, input logic [4:0] rt);
        stage_t s;
        s            = '0;
        s.alu_op     = ALU_OP_ADD;
        s.alu_src    = 1'b1;
        s.mem_read   = 1'b1;
        s.reg_write  = 1'b1;
        s.mem_to_reg = 1'b1;
        s.rs         = rs;
        s.rt         = rt;
        s.rs_data    = 32'h3000_0000 | {27'd0, rs};
        s.rt_data    = 32'h4000_0000 | {27'd0, rt};
        s.imm_ext    = 32'h0000_0010 | {27'd0, rt};
        s.pc8        = 32'h0040_0200 | {27'd0, rt};
        return s;
    endfunction

    function automatic stage_t mk_addi(input logic [4:0] rs, input logic [4:0] rt);
        stage_t s;
        s           = '0;
        s.alu_op    = ALU_OP_ADD;
        s.alu_src   = 1'b1;
        s.reg_write = 1'b1;
        s.rs        = rs;
        s.rt        = rt;
        s.rs_data   = 32'h5000_0000 | {27'd0, rs};
        s.imm_ext   = 32'hFFFF_FFF0;
        s.pc8       = 32'h0040_0300;
        return s;
    endfunction

    function automatic stage_t mk_sw(input logic [4:0] rs, input logic [4:0] rt);
        stage_t s;
        s           = '0;
        s.alu_op    = ALU_OP_ADD;
        s.alu_src   = 1'b1;
        s.mem_write = 1'b1;
        s.rs        = rs;
        s.rt        = rt;
        s.rs_data   = 32'h6000_0000 | {27'd0, rs};
        s.rt_data   = 32'h7000_0000 | {27'd0, rt};
        s.imm_ext   = 32'h0000_0044;
        s.pc8       = 32'h0040_0400;
        return s;
    endfunction

    function automatic stage_t mk_jal();
        stage_t s;
        s           = '0;
        s.jal_sel   = 1'b1;
        s.bds_sel   = 1'b1;
        s.reg_write = 1'b1;
        s.rd        = 5'd31;
        s.imm_ext   = 32'h0010_0042;
        s.pc8       = 32'h0040_0208;
        return s;
    endfunction

    function automatic stage_t bubble_of(input stage_t s);
        stage_t b;
        b            = s;
        b.alu_op     = '0;
        b.reg_dst    = 1'b0;
        b.jal_sel    = 1'b0;
        b.alu_src    = 1'b0;
        b.mem_read   = 1'b0;
        b.mem_write  = 1'b0;
        b.reg_write  = 1'b0;
        b.bds_sel    = 1'b0;
        b.mem_to_reg = 1'b0;
        return b;
    endfunction

    function automatic vec_t mkv(input stage_t s, input logic u, input logic en,
                                 input logic fl, input logic st, input kind_e k);
        vec_t v;
        v.d         = s;
        v.uses_rt   = u;
        v.enable    = en;
        v.flush     = fl;
        v.exp_stall = st;
        v.kind      = k;
        return v;
    endfunction

    // Drive one vector mid-cycle, check the combinational stall, then check
    // the registered result one edge later through the scoreboard.
    task automatic apply(input vec_t v, input int idx);
        exp_t x;
        exp_t got;
        @(negedge clk);
        d       = v.d;
        uses_rt = v.uses_rt;
        enable  = v.enable;
        flush   = v.flush;
        #1;
        check_bit($sformatf("row%0d stall", idx), stall, v.exp_stall);
        case (v.kind)
            K_CAP:   begin x.e = v.d;           x.valid = 1'b1; end
            K_BUB:   begin x.e = bubble_of(v.d); x.valid = 1'b0; end
            default: x = model;
        endcase
        sb_q.push_back(x);
        model = x;
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_stage($sformatf("row%0d e_outputs", idx), e_act, got.e);
        check_bit($sformatf("row%0d valid", idx), valid_e, got.valid);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        stage_t hold_d;

        vecs[0]  = mkv(mk_addu(5'd1, 5'd2, 5'd3),  1'b1, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[1]  = mkv(mk_lw(5'd1, 5'd2),          1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[2]  = mkv(mk_addu(5'd2, 5'd4, 5'd5),  1'b1, 1'b1, 1'b0, 1'b1, K_BUB);
        vecs[3]  = mkv(mk_addu(5'd2, 5'd4, 5'd5),  1'b1, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[4]  = mkv(mk_lw(5'd3, 5'd0),          1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[5]  = mkv(mk_addu(5'd0, 5'd0, 5'd6),  1'b1, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[6]  = mkv(mk_lw(5'd1, 5'd2),          1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[7]  = mkv(mk_addi(5'd3, 5'd2),        1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[8]  = mkv(mk_lw(5'd1, 5'd7),          1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[9]  = mkv(mk_addu(5'd4, 5'd7, 5'd5),  1'b1, 1'b1, 1'b0, 1'b1, K_BUB);
        vecs[10] = mkv(mk_addu(5'd4, 5'd7, 5'd5),  1'b1, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[11] = mkv(mk_lw(5'd1, 5'd8),          1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[12] = mkv(mk_lw(5'd8, 5'd8),          1'b0, 1'b1, 1'b0, 1'b1, K_BUB);
        vecs[13] = mkv(mk_lw(5'd8, 5'd8),          1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[14] = mkv(mk_addu(5'd8, 5'd1, 5'd5),  1'b1, 1'b1, 1'b0, 1'b1, K_BUB);
        vecs[15] = mkv(mk_addu(5'd8, 5'd1, 5'd5),  1'b1, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[16] = mkv(mk_lw(5'd1, 5'd9),          1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[17] = mkv(mk_addu(5'd9, 5'd1, 5'd5),  1'b1, 1'b1, 1'b1, 1'b0, K_BUB);
        vecs[18] = mkv(mk_addu(5'd9, 5'd1, 5'd5),  1'b1, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[19] = mkv(mk_lw(5'd1, 5'd10),         1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[20] = mkv(mk_addu(5'd10, 5'd1, 5'd5), 1'b1, 1'b0, 1'b0, 1'b0, K_HOLD);
        vecs[21] = mkv(mk_jal(),                   1'b0, 1'b0, 1'b0, 1'b0, K_HOLD);
        vecs[22] = mkv(mk_addi(5'd10, 5'd3),       1'b0, 1'b0, 1'b0, 1'b0, K_HOLD);
        vecs[23] = mkv(mk_addu(5'd10, 5'd1, 5'd5), 1'b1, 1'b1, 1'b0, 1'b1, K_BUB);
        vecs[24] = mkv(mk_addu(5'd10, 5'd1, 5'd5), 1'b1, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[25] = mkv(mk_jal(),                   1'b0, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[26] = mkv(mk_sw(5'd1, 5'd4),          1'b1, 1'b1, 1'b0, 1'b0, K_CAP);
        vecs[27] = mkv(mk_lw(5'd2, 5'd4),          1'b0, 1'b1, 1'b0, 1'b0, K_CAP);

        // Reset with live D inputs: everything must read zero.
        rst_n   = 1'b0;
        enable  = 1'b0;
        flush   = 1'b0;
        d       = mk_addu(5'd1, 5'd2, 5'd3);
        uses_rt = 1'b1;
        #2;
        check_stage("reset e_outputs", e_act, '0);
        check_bit("reset valid", valid_e, 1'b0);
        check_bit("reset stall", stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model.e     = '0;
        model.valid = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], i);
        end

        // Reset asserted mid-cycle while a load-use stall is being signalled.
        apply(mkv(mk_lw(5'd1, 5'd2), 1'b0, 1'b1, 1'b0, 1'b0, K_CAP), 100);
        @(negedge clk);
        hold_d  = mk_addu(5'd2, 5'd4, 5'd5);
        d       = hold_d;
        uses_rt = 1'b1;
        enable  = 1'b1;
        flush   = 1'b0;
        #1;
        check_bit("midstall stall_before_reset", stall, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_stage("midstall reset e_outputs", e_act, '0);
        check_bit("midstall reset valid", valid_e, 1'b0);
        check_bit("midstall reset stall", stall, 1'b0);
        @(posedge clk);
        #1;
        check_stage("reset held across edge", e_act, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_stage("first edge after reset captures", e_act, hold_d);
        check_bit("first edge after reset valid", valid_e, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_stage
